dec_entry: RTL
==============

DEC_ENTRY -- requirements
Module: dec_entry

Interface
REQ-001 SHALL have parameter DB_COUNT, default 1000000, meaning the key debounce stability period in clk cycles (20 ms at 50 MHz); must be >= 2.
REQ-002 SHALL have port clk, input, 1, the single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port n_reset, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port key, input, 1, raw asynchronous pushbutton; 0 = pressed.
REQ-005 SHALL have port digit, input, 4, BCD digit from switches.
REQ-006 SHALL have port neg, input, 1, sign switch; 1 = negative.
REQ-007 SHALL have port value, output, 8, last accepted result in two's complement.
REQ-008 SHALL have port valid, output, 1, one-cycle strobe when value updates.
REQ-009 SHALL have port error, output, 1, level flag for a rejected entry.
REQ-010 SHALL have port stage, output, 2, digit position awaited: 0 hundreds, 1 tens, 2 units.

Function
REQ-011 SHALL pass key through a 2-flop synchroniser before any other use.
REQ-012 SHALL keep a debounced level (stable) and a counter: counter clears whenever the synchronised key equals stable; otherwise it increments, and on reaching DB_COUNT-1 stable takes the synchronised value and the counter clears.
REQ-013 SHALL produce an internal press strobe for exactly one cycle when stable changes from 1 to 0; releases produce no event.
REQ-014 SHALL treat a low pulse shorter than DB_COUNT synchronised cycles as a glitch that produces no press.
REQ-015 SHALL implement FSM states HUND, TENS, UNITS, CONV; reset state HUND.
REQ-016 On press in HUND: acc <= digit; error <= 0; next state TENS.
REQ-017 On press in TENS: acc <= acc*10 + digit; next state UNITS.
REQ-018 On press in UNITS: acc <= acc*10 + digit; neg is sampled into sgn; next state CONV.
REQ-019 SHALL hold acc as 10 bits unsigned (range 0..999) with no overflow.
REQ-020 In CONV (exactly one cycle), SHALL evaluate the range check:
  - ok = (sgn=0 and acc<=127) or (sgn=1 and acc<=128).
  - If ok: value <= sgn ? -acc[7:0] : acc[7:0]; valid=1 for that one cycle; error <= 0.
  - If not ok: value is unchanged; valid stays 0; error <= 1.
  - In both cases, next state is HUND.
REQ-021 On any press with digit > 9, SHALL set error to 1, clear acc, return to HUND, and leave value and valid unchanged.
REQ-022 SHALL keep error asserted until the next press in HUND or until reset.
REQ-023 SHALL ignore digit and neg except in the press cycle, and SHALL ignore presses in CONV (unreachable within the debounce window).
REQ-024 SHALL drive stage from the FSM: HUND=0, TENS=1, UNITS=2, CONV=2.
REQ-025 valid SHALL be registered and never high on two consecutive cycles.
REQ-026 -0 SHALL yield value 0x00 as a valid result.

Reset
REQ-027 While n_reset=0 at a clk edge, SHALL set: value=0x00, valid=0, error=0, stage=0, FSM=HUND, acc=0, sgn=0, synchroniser flops=1, stable=1, debounce counter=0.
REQ-028 Reset mid-entry SHALL discard partial digits with no valid or error output.
REQ-029 If key is held through reset release, SHALL generate one press DB_COUNT+2 cycles later, as for a normal press.

Verification (DB_COUNT=4)
REQ-030 Enter digits 1,2,7 with neg=0 -> one valid pulse, value=0x7F, error=0, stage returns to 0.
REQ-031 Enter digits 1,2,8 with neg=1 -> valid pulse, value=0x80; then 1,2,8 with neg=0 -> error=1, no valid, value stays 0x80.
REQ-032 Enter digit 0xA at the tens position -> error=1, stage=0, value unchanged; the next press in HUND clears error.
REQ-033 key low for 2 cycles (glitch) -> no stage change; key low for 10 cycles with 1-cycle bounces at start -> exactly one press.
REQ-034 Assert reset after two digits, then enter 0,0,5 with neg=1 -> value=0xFB; enter 0,0,0 with neg=1 -> value=0x00, valid pulse.
REQ-035 Hold key low across reset release -> exactly one press, stage=1 after DB_COUNT+2 cycles.

Source files
------------

// File: rtl/dec_entry.sv
// Three-digit signed BCD entry from a debounced pushbutton.
// Converts hundreds/tens/units plus sign into an 8-bit two's complement value.
module dec_entry #(
  parameter int DB_COUNT = 1000000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       key,
  input  logic [3:0] digit,
  input  logic       neg,
  output logic [7:0] value,
  output logic       valid,
  output logic       error,
  output logic [1:0] stage
);

  localparam int CW = (DB_COUNT > 2) ? $clog2(DB_COUNT) : 1;

  typedef enum logic [1:0] {
    HUND,
    TENS,
    UNITS,
    CONV
  } state_t;

  state_t state;
  state_t state_n;

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          done;
  logic          press;

  logic [9:0] acc;
  logic [9:0] acc_n;
  logic [9:0] acc10;
  logic       sgn;
  logic       sgn_n;
  logic [7:0] value_n;
  logic       valid_n;
  logic       error_n;
  logic       bad;
  logic       ok;

  // Two-flop synchroniser; idles high (released).
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  assign done = (cnt == CW'(DB_COUNT - 1));

  // Debounce: a new level must persist DB_COUNT cycles to be adopted.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt    <= '0;
    end else if (done) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end

  // Press fires in the same cycle stable falls, so the FSM
  // advances on the very edge that adopts the pressed level.
  assign press = stable & ~s2 & done;

  // Entry FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= HUND;
      acc   <= '0;
      sgn   <= 1'b0;
      value <= '0;
      valid <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      sgn   <= sgn_n;
      value <= value_n;
      valid <= valid_n;
      error <= error_n;
    end
  end

  assign bad   = (digit > 4'd9);
  assign acc10 = acc * 10'd10 + {6'd0, digit};
  assign ok    = sgn ? (acc <= 10'd128) : (acc <= 10'd127);

  // Next-state and datapath updates; a bad digit aborts the entry.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    sgn_n   = sgn;
    value_n = value;
    valid_n = 1'b0;
    error_n = error;
    unique case (state)
      HUND: begin
        if (press) begin
          if (bad) begin
            error_n = 1'b1;
            acc_n   = '0;
          end else begin
            acc_n   = {6'd0, digit};
            error_n = 1'b0;
            state_n = TENS;
          end
        end
      end
      TENS: begin
        if (press) begin
          if (bad) begin
            error_n = 1'b1;
            acc_n   = '0;
            state_n = HUND;
          end else begin
            acc_n   = acc10;
            state_n = UNITS;
          end
        end
      end
      UNITS: begin
        if (press) begin
          if (bad) begin
            error_n = 1'b1;
            acc_n   = '0;
            state_n = HUND;
          end else begin
            acc_n   = acc10;
            sgn_n   = neg;
            state_n = CONV;
          end
        end
      end
      CONV: begin
        state_n = HUND;
        if (ok) begin
          value_n = sgn ? (8'd0 - acc[7:0]) : acc[7:0];
          valid_n = 1'b1;
          error_n = 1'b0;
        end else begin
          error_n = 1'b1;
        end
      end
      default: state_n = HUND;
    endcase
  end

  // Digit position shown to the user; CONV still reports units.
  always_comb begin
    stage = 2'd0;
    unique case (state)
      HUND:    stage = 2'd0;
      TENS:    stage = 2'd1;
      UNITS:   stage = 2'd2;
      CONV:    stage = 2'd2;
      default: stage = 2'd0;
    endcase
  end

endmodule
